// File: rtl/rom_fetch_pkg.sv
// Shared constants for the instruction ROM and its fetch front end.
// Also holds the credit check that decides whether a new ROM read may issue.
package rom_fetch_pkg;

    localparam int ROM_ADDR_W    = 8;
    localparam int ROM_DEPTH     = 1 << ROM_ADDR_W;
    localparam int WORD_DATA_W   = 32;
    localparam int IF_FIFO_DEPTH = 2;
    localparam int ROM_RESET_PC  = 0;

    // Buffered words plus the read in flight, less the word leaving now,
    // must stay below the FIFO depth for a new read to have a guaranteed slot.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] held;
        logic [2:0] limit;
        held  = {1'b0, occ} + {2'b00, inflight};
        limit = 3'(IF_FIFO_DEPTH) + {2'b00, pop};
        return held < limit;
    endfunction

endpackage

// File: rtl/if_skid_fifo.sv
// Two-entry {pc, insn} FIFO between the ROM read port and decode.
// The head lives directly in the output registers; flush clears everything.
module if_skid_fifo #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [DATA_W-1:0] push_insn,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              valid,
    output logic [PC_W-1:0]   head_pc,
    output logic [DATA_W-1:0] head_insn
);

    logic [PC_W-1:0]   tail_pc;
    logic [DATA_W-1:0] tail_insn;
    logic              do_pop;

    assign do_pop = pop && (occ != 2'd0);
    assign valid  = (occ != 2'd0);

    always_ff @(posedge clk) begin
        if (flush) begin
            occ       <= 2'd0;
            head_pc   <= '0;
            head_insn <= '0;
            tail_pc   <= '0;
            tail_insn <= '0;
        end else begin
            case ({push, do_pop})
                2'b11: begin
                    if (occ == 2'd2) begin
                        head_pc   <= tail_pc;
                        head_insn <= tail_insn;
                        tail_pc   <= push_pc;
                        tail_insn <= push_insn;
                    end else begin
                        head_pc   <= push_pc;
                        head_insn <= push_insn;
                    end
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_insn <= tail_insn;
                    occ       <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_pc   <= push_pc;
                        head_insn <= push_insn;
                    end else begin
                        tail_pc   <= push_pc;
                        tail_insn <= push_insn;
                    end
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// Instruction-fetch requester: drives the synchronous ROM, absorbs its one-cycle
// latency and hands {pc, insn} to decode over valid/ready, with redirect support.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ROM_ADDR_W,
    parameter int                DATA_W   = WORD_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ROM_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [1:0]        occ;
    logic              pop;
    logic              can_issue;
    logic              push;
    logic              flush;

    assign pop       = if_valid && if_ready;
    assign can_issue = credit_ok(occ, inflight, pop);
    assign flush     = rst || redirect_valid;
    assign push      = inflight && !redirect_valid;

    // The ROM has no enable, so when nothing issues the address simply holds.
    always_comb begin
        rom_addr = fetch_pc;
        if (rst) begin
            rom_addr = RESET_PC;
        end else if (redirect_valid) begin
            rom_addr = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc + 1'b1;
            inflight    <= 1'b1;
            inflight_pc <= redirect_pc;
        end else if (can_issue) begin
            fetch_pc    <= fetch_pc + 1'b1;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight    <= 1'b0;
        end
    end

    if_skid_fifo #(
        .PC_W   (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .flush     (flush),
        .push      (push),
        .push_pc   (inflight_pc),
        .push_insn (rom_data),
        .pop       (pop),
        .occ       (occ),
        .valid     (if_valid),
        .head_pc   (if_pc),
        .head_insn (if_insn)
    );

endmodule
